ext_storage_spi_ctrl: RTL and testbench
=======================================

EXT_STORAGE_SPI_CTRL -- requirements
Module: ext_storage_spi_ctrl

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 2: clk cycles per SCK half-period, legal range 1..255.
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port req_i  input  1  word read request from the mmu.
REQ-005 SHALL have port addr_i  input  24  flash byte address of the word.
REQ-006 SHALL have port ready_o  output  1  high when idle and able to accept req_i.
REQ-007 SHALL have port rvalid_o  output  1  one-cycle pulse marking rdata_o valid.
REQ-008 SHALL have port rdata_o  output  32  read word.
REQ-009 SHALL have port external_storage_spi_cs_n  output  1  flash chip select, active-low.
REQ-010 SHALL have port external_storage_spi_sck  output  1  flash serial clock.
REQ-011 SHALL have port external_storage_spi_mosi  output  1  controller-to-flash data.
REQ-012 SHALL have port external_storage_spi_miso  input  1  flash-to-controller data.

Function
REQ-013 SHALL implement states IDLE, CMD, ADDR, DATA and DONE.
REQ-014 SHALL accept a request only when req_i=1 and ready_o=1 at a clk edge.
- At acceptance, SHALL latch addr_i.
- At acceptance, SHALL enter CMD.
REQ-015 SHALL drive ready_o=1 only in IDLE.
REQ-016 SHALL ignore req_i in every other state, including DONE; no queuing.
REQ-017 SHALL ignore changes on addr_i after acceptance.
REQ-018 SHALL use SPI mode 0 in CMD, ADDR and DATA:
- SCK idles low.
- SCK toggles every CLK_DIV cycles.
- Each bit lasts 2*CLK_DIV cycles, starting with SCK low.
REQ-019 SHALL update MOSI only at the start of a bit (SCK low phase).
REQ-020 SHALL sample MISO on the clk edge where SCK goes 0->1.
REQ-021 SHALL send and receive each byte MSB first.
REQ-022 In CMD, SHALL shift out 8 bits of opcode 0x03 (READ).
REQ-023 In ADDR, SHALL shift out the 24 latched address bits, bit 23 first.
REQ-024 In DATA, SHALL shift in 32 bits; MOSI=0 throughout DATA.
REQ-025 SHALL assemble received bytes little-endian:
- 1st byte -> rdata[7:0]
- 2nd byte -> rdata[15:8]
- 3rd byte -> rdata[23:16]
- 4th byte -> rdata[31:24]
REQ-026 SHALL hold cs_n low continuously from the first CMD cycle through the last DATA cycle.
REQ-027 SHALL hold cs_n high in IDLE and DONE.
REQ-028 SHALL produce exactly 64 SCK rising edges per transaction.
REQ-029 SHALL end every transaction with SCK low.
REQ-030 After the last DATA bit, SHALL enter DONE for exactly one cycle.
- In DONE, rvalid_o=1 and rdata_o holds the new word.
- The cycle after DONE, SHALL enter IDLE.
REQ-031 Latency: a request accepted at edge T SHALL give rvalid_o high in cycle T+128*CLK_DIV+1.
- CLK_DIV=2 -> T+257.
- CLK_DIV=1 -> T+129.
REQ-032 SHALL hold rdata_o at its last value until the next DONE.
REQ-033 SHALL keep rvalid_o low in every state except DONE.
REQ-034 Address wrap: SHALL send address 0xFFFFFF unmodified; internal counters SHALL not overflow at any CLK_DIV in range.

Reset
REQ-035 With rst=0 at a clk edge, SHALL set on the next cycle:
- state IDLE, ready_o=1, rvalid_o=0, rdata_o=0
- cs_n=1, sck=0, mosi=0
REQ-036 Reset mid-transaction SHALL abort immediately:
- no rvalid_o pulse
- cs_n high and sck low the next cycle
- a new request accepted on the first edge after rst returns to 1

Verification
REQ-037 Reset check: assert rst=0 for 2 cycles -> outputs equal REQ-035 values.
REQ-038 Single read, CLK_DIV=2, addr 0x000104, flash model returns 0xEF,0xBE,0xAD,0xDE -> required response:
- MOSI bytes 0x03,0x00,0x01,0x04
- rvalid_o at T+257
- rdata_o=0xDEADBEEF
- 64 SCK rising edges with cs_n low throughout
REQ-039 Busy request: hold req_i=1 for 300 cycles -> exactly one transaction before ready_o returns; a second begins only at the next ready_o=1 edge.
REQ-040 Mid-transaction reset: assert rst=0 after the 40th SCK rising edge -> no rvalid_o, cs_n=1 and sck=0 next cycle; a following read of 0x000000 returning 0x11,0x22,0x33,0x44 -> rdata_o=0x44332211.
REQ-041 Back-to-back reads, CLK_DIV=1, addr 0xFFFFFF then 0x000000 -> MOSI shows FF FF FF then 00 00 00 after opcode; each rvalid_o at acceptance+129; cs_n high at least 2 cycles between transactions.

Source files
------------

// File: rtl/ext_storage_spi_ctrl.sv
// ext_storage_spi_ctrl: SPI mode-0 flash word reader issuing READ (0x03), a 24-bit address,
// then clocking in a 32-bit word that is assembled little-endian.
module ext_storage_spi_ctrl #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic [23:0] addr_i,
    output logic        ready_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        external_storage_spi_cs_n,
    output logic        external_storage_spi_sck,
    output logic        external_storage_spi_mosi,
    input  logic        external_storage_spi_miso
);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE} state_t;
    localparam logic [7:0] HC_MAX = 8'(CLK_DIV - 1);
    state_t      state, state_nx;
    logic [7:0]  hc;
    logic [5:0]  bit_cnt;
    logic [31:0] tx, rx;
    logic        sck, busy, half_end, bit_end;
    always_ff @(posedge clk) begin
        state <= !rst ? IDLE : state_nx;
    end
    always_comb begin
        state_nx = (state == IDLE && req_i)                       ? CMD  :
                   (state == CMD  && bit_end && bit_cnt == 6'd7)  ? ADDR :
                   (state == ADDR && bit_end && bit_cnt == 6'd31) ? DATA :
                   (state == DATA && bit_end && bit_cnt == 6'd63) ? DONE :
                   (state == DONE)                                ? IDLE : state;
    end
    always_comb begin
        busy                      = state inside {CMD, ADDR, DATA};
        half_end                  = busy && hc == HC_MAX;
        bit_end                   = half_end && sck;
        ready_o                   = state == IDLE;
        rvalid_o                  = state == DONE;
        external_storage_spi_cs_n = !busy;
        external_storage_spi_sck  = sck;
        external_storage_spi_mosi = tx[31];
    end
    // tx holds opcode+address and drains to zero, so MOSI is 0 through DATA and when idle
    always_ff @(posedge clk) begin
        if (!rst) begin
            hc      <= '0;
            bit_cnt <= '0;
            sck     <= 1'b0;
            tx      <= '0;
            rx      <= '0;
            rdata_o <= '0;
        end else if (state == IDLE && req_i) begin
            hc      <= '0;
            bit_cnt <= '0;
            sck     <= 1'b0;
            tx      <= {8'h03, addr_i};
        end else if (busy) begin
            hc <= half_end ? 8'd0 : hc + 8'd1;
            if (half_end) sck <= !sck;
            if (half_end && !sck) rx <= {rx[30:0], external_storage_spi_miso};
            if (bit_end) begin
                tx      <= {tx[30:0], 1'b0};
                bit_cnt <= bit_cnt + 6'd1;
            end
            if (bit_end && state == DATA && bit_cnt == 6'd63)
                rdata_o <= {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
        end
    end
endmodule

// File: tb/tb_ext_storage_spi_ctrl.sv
// tb_ext_storage_spi_ctrl: directed checks of the flash reader at CLK_DIV=2 (dut0) and CLK_DIV=1 (dut1)
module tb_ext_storage_spi_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        req[2];
    logic [23:0] addr[2];
    logic        ready[2], rvalid[2], cs_n[2], sck[2], mosi[2], miso[2];
    logic [31:0] rdata[2];
    logic [31:0] stream[2];
    logic [6:0]  rises[2], total[2];
    logic [31:0] cap[2];
    logic        sck_q[2], cs_q[2];
    int          txn[2], bad[2], hi_run[2], gap[2];
    int          checks = 0, failures = 0;
    int          lat, wt, n, nacc, nrv;
    int          acc_k[2];

    always #5 clk = ~clk;

    ext_storage_spi_ctrl #(.CLK_DIV(2)) dut0 (
        .clk(clk), .rst(rst), .req_i(req[0]), .addr_i(addr[0]), .ready_o(ready[0]),
        .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .external_storage_spi_cs_n(cs_n[0]),
        .external_storage_spi_sck(sck[0]), .external_storage_spi_mosi(mosi[0]),
        .external_storage_spi_miso(miso[0])
    );
    ext_storage_spi_ctrl #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .req_i(req[1]), .addr_i(addr[1]), .ready_o(ready[1]),
        .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .external_storage_spi_cs_n(cs_n[1]),
        .external_storage_spi_sck(sck[1]), .external_storage_spi_mosi(mosi[1]),
        .external_storage_spi_miso(miso[1])
    );

    // Flash model: bytes of stream go out MSB first once the 32 command/address bits are in
    assign miso[0] = (rises[0] >= 7'd32) ? stream[0][5'(7'd63 - rises[0])] : 1'b0;
    assign miso[1] = (rises[1] >= 7'd32) ? stream[1][5'(7'd63 - rises[1])] : 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                rises[i] <= '0; total[i] <= '0; cap[i] <= '0; sck_q[i] <= 1'b0; cs_q[i] <= 1'b1;
                txn[i] <= 0; bad[i] <= 0; hi_run[i] <= 0; gap[i] <= 0;
            end else begin
                sck_q[i]  <= sck[i];
                cs_q[i]   <= cs_n[i];
                hi_run[i] <= cs_n[i] ? hi_run[i] + 1 : 0;
                if (cs_n[i]) rises[i] <= '0;
                else if (sck[i] && !sck_q[i]) begin
                    rises[i] <= rises[i] + 7'd1;
                    if (rises[i] < 7'd32) cap[i] <= {cap[i][30:0], mosi[i]};
                end
                if (cs_n[i] && sck[i] && !sck_q[i]) bad[i] <= bad[i] + 1;
                if (cs_n[i] && !cs_q[i]) total[i] <= rises[i];
                if (!cs_n[i] && cs_q[i]) begin
                    txn[i] <= txn[i] + 1;
                    gap[i] <= hi_run[i];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // lat counts cycles from acceptance: cycle 1 is the one right after the accepting edge
    task automatic do_read(input int i, input logic [23:0] a, output int l, output int w);
        addr[i] = a;
        req[i]  = 1'b1;
        w = 0;
        while (!ready[i] && w < 1000) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk); #1;
        req[i]  = 1'b0;
        addr[i] = ~a;
        l = 1;
        while (!rvalid[i] && l < 1000) begin
            @(posedge clk); #1;
            l++;
        end
    endtask

    initial begin
        rst = 1'b0;
        req[0] = 1'b0; req[1] = 1'b0;
        addr[0] = '0; addr[1] = '0;
        stream[0] = '0; stream[1] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", ready[0], 1'b1);
        chk("rst_rvalid", rvalid[0], 1'b0);
        chk("rst_rdata", rdata[0], 32'h0);
        chk("rst_cs_n", cs_n[0], 1'b1);
        chk("rst_sck", sck[0], 1'b0);
        chk("rst_mosi", mosi[0], 1'b0);
        chk("rst_ready1", ready[1], 1'b1);
        chk("rst_cs_n1", cs_n[1], 1'b1);
        @(negedge clk);
        rst = 1'b1;

        // single read at CLK_DIV=2
        stream[0] = 32'hEFBEADDE;
        @(negedge clk);
        do_read(0, 24'h000104, lat, wt);
        chk("rd_latency", lat, 257);
        chk("rd_rdata", rdata[0], 32'hDEADBEEF);
        chk("rd_mosi", cap[0], 32'h03000104);
        @(posedge clk); #1;
        chk("rd_rvalid_pulse", rvalid[0], 1'b0);
        chk("rd_ready_back", ready[0], 1'b1);
        chk("rd_sck_rises", total[0], 64);
        chk("rd_cs_once", txn[0], 1);
        repeat (5) @(posedge clk);
        #1;
        chk("rd_hold", rdata[0], 32'hDEADBEEF);

        // request held high for 300 cycles
        stream[0] = 32'h78563412;
        @(negedge clk);
        addr[0] = 24'h123456;
        req[0]  = 1'b1;
        nacc = 0; nrv = 0;
        for (int k = 0; k < 300; k++) begin
            if (ready[0]) begin
                if (nacc < 2) acc_k[nacc] = k;
                nacc++;
            end
            if (rvalid[0]) nrv++;
            @(negedge clk);
        end
        req[0] = 1'b0;
        chk("busy_accepts", nacc, 2);
        chk("busy_second_at", acc_k[1], 258);
        chk("busy_rvalids", nrv, 1);
        n = 0;
        while (!rvalid[0] && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk("busy_done", rvalid[0], 1'b1);
        chk("busy_rdata", rdata[0], 32'h12345678);
        chk("busy_mosi", cap[0], 32'h03123456);
        chk("busy_txn", txn[0], 3);

        // reset after the 40th SCK rise
        @(posedge clk); #1;
        @(negedge clk);
        addr[0] = 24'h000555;
        req[0]  = 1'b1;
        @(posedge clk); #1;
        req[0] = 1'b0;
        n = 0;
        while (rises[0] != 7'd40 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("mid_reached40", rises[0], 40);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("mid_cs_n", cs_n[0], 1'b1);
        chk("mid_sck", sck[0], 1'b0);
        chk("mid_rvalid", rvalid[0], 1'b0);
        chk("mid_mosi", mosi[0], 1'b0);
        @(negedge clk);
        rst = 1'b1;
        stream[0] = 32'h11223344;
        do_read(0, 24'h000000, lat, wt);
        chk("mid_accept_first", wt, 0);
        chk("mid_latency", lat, 257);
        chk("mid_rdata", rdata[0], 32'h44332211);

        // back-to-back at CLK_DIV=1
        stream[1] = 32'h5AC30FF0;
        @(negedge clk);
        do_read(1, 24'hFFFFFF, lat, wt);
        chk("b2b1_latency", lat, 129);
        chk("b2b1_rdata", rdata[1], 32'hF00FC35A);
        chk("b2b1_mosi", cap[1], 32'h03FFFFFF);
        stream[1] = 32'h01020304;
        do_read(1, 24'h000000, lat, wt);
        chk("b2b2_latency", lat, 129);
        chk("b2b2_rdata", rdata[1], 32'h04030201);
        chk("b2b2_mosi", cap[1], 32'h03000000);
        chk("b2b_cs_gap", gap[1], 2);
        @(posedge clk); #1;
        chk("b2b2_sck_rises", total[1], 64);
        chk("idle_sck0", bad[0], 0);
        chk("idle_sck1", bad[1], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
